// File: rtl/msg_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : msg_tx_scheduler_if
//  Brief    : Per-channel length/data FIFO handshakes plus the shared transmit
//             port of the two-channel message scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface msg_tx_scheduler_if;
    logic        LEN_EMPTY_0;
    logic        LEN_EMPTY_1;
    logic [7:0]  LEN_Q_0;
    logic [7:0]  LEN_Q_1;
    logic        LEN_RDREQ_0;
    logic        LEN_RDREQ_1;
    logic        DATA_EMPTY_0;
    logic        DATA_EMPTY_1;
    logic [15:0] DATA_Q_0;
    logic [15:0] DATA_Q_1;
    logic        DATA_RDREQ_0;
    logic        DATA_RDREQ_1;
    logic        TX_READY;
    logic [15:0] P_DATA_OUT;
    logic        P_ENA_OUT;

    // Scheduler side: consumes FIFO heads, drives pops and the transmit word.
    modport master (
        input  LEN_EMPTY_0, LEN_EMPTY_1, LEN_Q_0, LEN_Q_1,
        input  DATA_EMPTY_0, DATA_EMPTY_1, DATA_Q_0, DATA_Q_1,
        input  TX_READY,
        output LEN_RDREQ_0, LEN_RDREQ_1, DATA_RDREQ_0, DATA_RDREQ_1,
        output P_DATA_OUT, P_ENA_OUT
    );

    // FIFO / downstream side.
    modport slave (
        output LEN_EMPTY_0, LEN_EMPTY_1, LEN_Q_0, LEN_Q_1,
        output DATA_EMPTY_0, DATA_EMPTY_1, DATA_Q_0, DATA_Q_1,
        output TX_READY,
        input  LEN_RDREQ_0, LEN_RDREQ_1, DATA_RDREQ_0, DATA_RDREQ_1,
        input  P_DATA_OUT, P_ENA_OUT
    );
endinterface
`default_nettype wire

// File: rtl/msg_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : msg_tx_scheduler
//  Brief    : Round-robin two-channel message scheduler with idle gap between
//             messages; streams whole messages from length/data FIFO pairs.
//  Revision : 1.0 - initial release
// ============================================================================
module msg_tx_scheduler #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    msg_tx_scheduler_if.master bus,
    output logic               CUR_CH,
    output logic               BUSY,
    output logic [7:0]         msg_counter,
    output logic               UNDERRUN,
    output logic               LEN_ERR,
    output logic [1:0]         state_mon
);

    localparam int unsigned c_gap_w = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);
    localparam bit c_has_gap = (GAP_CYCLES > 0);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_send = 2'd1;
    localparam logic [1:0] c_gap  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               last_ch_q, last_ch_d;
    logic               cur_ch_q, cur_ch_d;
    logic [7:0]         remaining_q, remaining_d;
    logic [c_gap_w-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]        p_data_q, p_data_d;
    logic               p_ena_q, p_ena_d;
    logic [7:0]         msg_cnt_q, msg_cnt_d;
    logic               underrun_q, underrun_d;
    logic               len_err_q, len_err_d;

    logic               w_pend0;
    logic               w_pend1;
    logic               w_sel;
    logic [7:0]         w_sel_len;
    logic               w_cur_empty;
    logic [15:0]        w_cur_data;
    logic               w_len_pop;
    logic               w_data_pop;

    always_comb begin
        state_d     = state_q;
        last_ch_d   = last_ch_q;
        cur_ch_d    = cur_ch_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        p_data_d    = p_data_q;
        p_ena_d     = 1'b0;
        msg_cnt_d   = msg_cnt_q;
        underrun_d  = underrun_q;
        len_err_d   = len_err_q;
        w_len_pop   = 1'b0;
        w_data_pop  = 1'b0;

        w_pend0     = ~bus.LEN_EMPTY_0;
        w_pend1     = ~bus.LEN_EMPTY_1;
        // On a tie the channel not served last wins; otherwise take whichever is pending.
        w_sel       = (w_pend0 && w_pend1) ? ~last_ch_q : w_pend1;
        w_sel_len   = w_sel ? bus.LEN_Q_1 : bus.LEN_Q_0;
        w_cur_empty = cur_ch_q ? bus.DATA_EMPTY_1 : bus.DATA_EMPTY_0;
        w_cur_data  = cur_ch_q ? bus.DATA_Q_1 : bus.DATA_Q_0;

        case (state_q)
            c_idle: begin
                if (w_pend0 || w_pend1) begin
                    w_len_pop   = 1'b1;
                    cur_ch_d    = w_sel;
                    last_ch_d   = w_sel;
                    remaining_d = w_sel_len;
                    gap_cnt_d   = '0;
                    if (w_sel_len == 8'd0) begin
                        len_err_d = 1'b1;
                        state_d   = c_has_gap ? c_gap : c_idle;
                    end else begin
                        state_d   = c_send;
                    end
                end
            end
            c_send: begin
                if (bus.TX_READY) begin
                    if (w_cur_empty) begin
                        underrun_d = 1'b1;
                    end else begin
                        w_data_pop  = 1'b1;
                        p_ena_d     = 1'b1;
                        p_data_d    = w_cur_data;
                        remaining_d = remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            msg_cnt_d = msg_cnt_q + 8'd1;
                            gap_cnt_d = '0;
                            state_d   = c_has_gap ? c_gap : c_idle;
                        end
                    end
                end
            end
            c_gap: begin
                if (gap_cnt_q == c_gap_last) begin
                    state_d = c_idle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= c_idle;
            last_ch_q   <= 1'b1;
            cur_ch_q    <= 1'b0;
            remaining_q <= 8'd0;
            gap_cnt_q   <= '0;
            p_data_q    <= 16'd0;
            p_ena_q     <= 1'b0;
            msg_cnt_q   <= 8'd0;
            underrun_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ch_q   <= last_ch_d;
            cur_ch_q    <= cur_ch_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
            p_data_q    <= p_data_d;
            p_ena_q     <= p_ena_d;
            msg_cnt_q   <= msg_cnt_d;
            underrun_q  <= underrun_d;
            len_err_q   <= len_err_d;
        end
    end

    // Pops are suppressed while reset is held so an aborted message loses no extra entry.
    assign bus.LEN_RDREQ_0  = w_len_pop  & ~w_sel    & ~RST;
    assign bus.LEN_RDREQ_1  = w_len_pop  &  w_sel    & ~RST;
    assign bus.DATA_RDREQ_0 = w_data_pop & ~cur_ch_q & ~RST;
    assign bus.DATA_RDREQ_1 = w_data_pop &  cur_ch_q & ~RST;
    assign bus.P_DATA_OUT   = p_data_q;
    assign bus.P_ENA_OUT    = p_ena_q;

    assign CUR_CH      = cur_ch_q;
    assign BUSY        = (state_q != c_idle);
    assign msg_counter = msg_cnt_q;
    assign UNDERRUN    = underrun_q;
    assign LEN_ERR     = len_err_q;
    assign state_mon   = state_q;

endmodule
`default_nettype wire

// File: doc/msg_tx_scheduler.md
# msg_tx_scheduler

Two-channel transmit scheduler placed after the per-channel capacity-check stages, one per receive link. Each channel provides a 16-bit message data FIFO and an 8-bit message-length FIFO. Each length entry is written only after all of that message's words are in the data FIFO. The block picks a channel round-robin, pops one length entry, then streams exactly that many words from the same channel to the shared transmit path. It inserts a programmable idle gap between messages and never interleaves words from two messages.

## Interface
Parameters:
- GAP_CYCLES, default 2: idle cycles inserted after each message (0 allowed).

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  reset, synchronous, active-high.
- LEN_EMPTY_0 / LEN_EMPTY_1  in  1  length FIFO empty, per channel.
- LEN_Q_0 / LEN_Q_1  in  8  length FIFO head (show-ahead), in words, valid while not empty.
- LEN_RDREQ_0 / LEN_RDREQ_1  out  1  length FIFO pop.
- DATA_EMPTY_0 / DATA_EMPTY_1  in  1  data FIFO empty.
- DATA_Q_0 / DATA_Q_1  in  16  data FIFO head (show-ahead).
- DATA_RDREQ_0 / DATA_RDREQ_1  out  1  data FIFO pop.
- TX_READY  in  1  downstream accepts a word this cycle.
- P_DATA_OUT  out  16  registered output word.
- P_ENA_OUT  out  1  registered output strobe.
- CUR_CH  out  1  channel being served.
- BUSY  out  1  high in any state other than IDLE.
- msg_counter  out  8  messages completed, wraps from 255 to 0.
- UNDERRUN  out  1  sticky flag: data FIFO was empty mid-message.
- LEN_ERR  out  1  sticky flag: zero-length entry popped.
- state_mon  out  2  current state encoding.

## Operation
- States:
  - IDLE = 0.
  - SEND = 1.
  - GAP = 2.
- IDLE:
  - If either LEN_EMPTY_x is low, choose a channel.
  - When both are pending, choose the channel not served last. last_ch resets to 1, so ch0 wins the first tie.
  - In that same cycle, assert LEN_RDREQ_x combinationally, latch LEN_Q_x into remaining[7:0], set CUR_CH and last_ch.
  - Non-zero length: go to SEND.
  - Zero length: set LEN_ERR and go to GAP. No words are sent and msg_counter is not incremented.
- SEND:
  - DATA_RDREQ_{CUR_CH} = TX_READY && !DATA_EMPTY_{CUR_CH}, combinational.
  - On each pop: register P_DATA_OUT <= DATA_Q_{CUR_CH}, set P_ENA_OUT <= 1, decrement remaining.
  - When TX_READY is high and the data FIFO is empty: set UNDERRUN, pop nothing, stay in SEND.
  - When TX_READY is low: stall silently.
  - The pop that takes remaining from 1 to 0 increments msg_counter and moves to GAP. If GAP_CYCLES = 0, it moves to IDLE instead.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - No pops of any FIFO.
- The other channel's RDREQ outputs stay 0 for the whole message.
- P_ENA_OUT is 0 on every cycle without a pop.
- P_DATA_OUT holds its last value when P_ENA_OUT is 0.
- Width rules:
  - remaining is 8 bits, so maximum message length is 255 words.
  - The gap counter is sized by $clog2(GAP_CYCLES+1), with a minimum of 1 bit.
- Reset values: state IDLE, all RDREQ 0, P_ENA_OUT 0, P_DATA_OUT 0, CUR_CH 0, BUSY 0, msg_counter 0, UNDERRUN 0, LEN_ERR 0, last_ch 1, remaining 0.
- RST asserted mid-message:
  - Abort the message. The next cycle is IDLE with reset values.
  - FIFOs are not flushed; the upstream reset is applied jointly.

## Timing
- Length pop occurs in the IDLE cycle t. The first data pop can occur at t+1, and the first P_ENA_OUT at t+2.
- With TX_READY held high, an L-word message occupies exactly 1 + L + GAP_CYCLES cycles from IDLE back to IDLE.
- Output latency from DATA_RDREQ to P_ENA_OUT/P_DATA_OUT is 1 cycle.
- msg_counter updates in the cycle after the last pop, coincident with the last P_ENA_OUT.
- LEN_RDREQ_x and DATA_RDREQ_x are each asserted for at most one cycle per popped entry or word.
- They are never asserted while the matching EMPTY input is high.

## Test plan
- Single message, GAP_CYCLES = 2:
  - Stimulus: ch0 length 3, words 0x55AA, 0x0140, 0x1234; TX_READY = 1.
  - Required: LEN_RDREQ_0 at t; DATA_RDREQ_0 at t+1..t+3; P_ENA_OUT at t+2..t+4 carrying those words in order; msg_counter = 1 at t+4; BUSY low at t+6.
- Both channels pending after reset, two messages each:
  - Required: service order ch0, ch1, ch0, ch1; CUR_CH follows that order; no cross-channel RDREQ.
- Back-pressure:
  - Stimulus: TX_READY low for 3 cycles after the 2nd word of a 5-word message.
  - Required: no pops and P_ENA_OUT = 0 during the stall; exactly 5 words delivered; UNDERRUN stays 0.
- Zero-length entry on ch1, followed by a 2-word message on ch0:
  - Required: LEN_ERR = 1; no ch1 data pops; ch0 message delivered intact; msg_counter = 1.
- Underrun:
  - Stimulus: ch0 length 4 with only 2 words present; 3rd word written 5 cycles later.
  - Required: UNDERRUN = 1; stall in SEND; all 4 words delivered once data arrives.
- Reset mid-message:
  - Stimulus: RST pulse during the 2nd word of a 4-word message.
  - Required: next cycle shows state_mon = 0, P_ENA_OUT = 0, msg_counter = 0, flags cleared.
